tcdm_bank_responder: RTL and testbench

Banked TCDM memory model that answers the `hwpe_stream_intf_tcdm` master ports driven by the HWPE streamers (load and store ports) and resolves bank conflicts between them. It sits on the far side of the accelerator's `tcdm[]` array, in standalone HWPE testbenches and in the FPGA/emulation shell. It owns word-interleaved single-port SRAM banks, a round-robin arbiter per bank, the grant/`r_valid` response pipeline and a conflict counter.

---
 rtl/tcdm_bank_responder_if.sv | 15 +
 rtl/tcdm_bank_responder.sv | 136 +++++++++++++
 tb/tb_tcdm_bank_responder.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tcdm_bank_responder_if.sv
// TCDM master/slave handshake bundle: request channel towards the memory,
// grant and one-cycle-later response channel back to the master.
interface hwpe_stream_intf_tcdm;
    logic        req;
    logic        gnt;
    logic [31:0] add;
    logic        wen;
    logic [3:0]  be;
    logic [31:0] data;
    logic [31:0] r_data;
    logic        r_valid;

    modport master (output req, add, wen, be, data, input gnt, r_data, r_valid);
    modport slave  (input req, add, wen, be, data, output gnt, r_data, r_valid);
endinterface

// File: rtl/tcdm_bank_responder.sv
// Word-interleaved banked TCDM model: per-bank round-robin arbitration with a
// combinational grant, one-cycle read/write response and a saturating conflict counter.
module tcdm_bank_responder #(
    parameter int unsigned N_PORTS    = 6,
    parameter int unsigned N_BANKS    = 8,
    parameter int unsigned BANK_WORDS = 256
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clear_i,
    hwpe_stream_intf_tcdm.slave tcdm [N_PORTS],
    output logic [31:0]         conflict_cnt_o
);
    localparam int unsigned BANK_BITS = $clog2(N_BANKS);
    localparam int unsigned ROW_BITS  = $clog2(BANK_WORDS);
    localparam int unsigned PTR_W     = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam int unsigned CNT_W     = $clog2(N_PORTS + 1);

    logic                 w_req       [N_PORTS];
    logic                 w_wen       [N_PORTS];
    logic [3:0]           w_be        [N_PORTS];
    logic [31:0]          w_add       [N_PORTS];
    logic [31:0]          w_wdata     [N_PORTS];
    logic [BANK_BITS-1:0] w_bank      [N_PORTS];
    logic [ROW_BITS-1:0]  w_row       [N_PORTS];
    logic                 w_gnt       [N_PORTS];
    logic                 w_unused_add[N_PORTS];

    logic                 r_valid     [N_PORTS];
    logic [31:0]          r_rdata     [N_PORTS];

    logic [PTR_W-1:0]     r_rr        [N_BANKS];
    logic                 w_bank_hit  [N_BANKS];
    logic [PTR_W-1:0]     w_bank_port [N_BANKS];

    logic [31:0]          r_mem       [N_BANKS][BANK_WORDS];

    logic [CNT_W-1:0]     w_conflicts;
    logic [32:0]          w_cnt_sum;
    logic [31:0]          r_conflict_cnt;

    // Only the bank/row field of the address matters; everything else aliases.
    for (genvar p = 0; p < N_PORTS; p++) begin : g_port
        assign w_req[p]        = tcdm[p].req;
        assign w_wen[p]        = tcdm[p].wen;
        assign w_be[p]         = tcdm[p].be;
        assign w_add[p]        = tcdm[p].add;
        assign w_wdata[p]      = tcdm[p].data;
        assign w_bank[p]       = w_add[p][2 +: BANK_BITS];
        assign w_row[p]        = w_add[p][2 + BANK_BITS +: ROW_BITS];
        assign w_unused_add[p] = ^w_add[p];
        assign tcdm[p].gnt     = w_gnt[p];
        assign tcdm[p].r_valid = r_valid[p];
        assign tcdm[p].r_data  = r_rdata[p];
    end

    // Scan offsets from the far end so the requester closest to the pointer wins.
    always_comb begin
        int idx;
        idx = 0;
        for (int b = 0; b < N_BANKS; b++) begin
            w_bank_hit[b]  = 1'b0;
            w_bank_port[b] = '0;
            for (int k = N_PORTS - 1; k >= 0; k--) begin
                idx = (int'(r_rr[b]) + k) % int'(N_PORTS);
                if (w_req[idx] && (w_bank[idx] == BANK_BITS'(b))) begin
                    w_bank_hit[b]  = 1'b1;
                    w_bank_port[b] = PTR_W'(idx);
                end
            end
        end
    end

    always_comb begin
        w_conflicts = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            w_gnt[p] = w_req[p] && w_bank_hit[w_bank[p]] &&
                       (w_bank_port[w_bank[p]] == PTR_W'(p));
            if (w_req[p] && !w_gnt[p]) begin
                w_conflicts = w_conflicts + CNT_W'(1);
            end
        end
        w_cnt_sum = {1'b0, r_conflict_cnt} + 33'(w_conflicts);
    end

    // Memory has no reset and is still written during a clear cycle.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < N_BANKS; b++) begin
            if (w_bank_hit[b] && !w_wen[w_bank_port[b]]) begin
                for (int i = 0; i < 4; i++) begin
                    if (w_be[w_bank_port[b]][i]) begin
                        r_mem[b][w_row[w_bank_port[b]]][8*i +: 8] <= w_wdata[w_bank_port[b]][8*i +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int p = 0; p < N_PORTS; p++) begin
                r_valid[p] <= 1'b0;
                r_rdata[p] <= '0;
            end
            for (int b = 0; b < N_BANKS; b++) begin
                r_rr[b] <= '0;
            end
            r_conflict_cnt <= '0;
        end else if (clear_i) begin
            for (int p = 0; p < N_PORTS; p++) begin
                r_valid[p] <= 1'b0;
                r_rdata[p] <= '0;
            end
            for (int b = 0; b < N_BANKS; b++) begin
                r_rr[b] <= '0;
            end
            r_conflict_cnt <= '0;
        end else begin
            for (int p = 0; p < N_PORTS; p++) begin
                r_valid[p] <= w_gnt[p];
                if (w_gnt[p] && w_wen[p]) begin
                    r_rdata[p] <= r_mem[w_bank[p]][w_row[p]];
                end
            end
            for (int b = 0; b < N_BANKS; b++) begin
                if (w_bank_hit[b]) begin
                    r_rr[b] <= (w_bank_port[b] == PTR_W'(N_PORTS - 1)) ? '0 : w_bank_port[b] + PTR_W'(1);
                end
            end
            r_conflict_cnt <= w_cnt_sum[32] ? '1 : w_cnt_sum[31:0];
        end
    end

    assign conflict_cnt_o = r_conflict_cnt;

endmodule

// File: tb/tb_tcdm_bank_responder.sv
// Bench for tcdm_bank_responder: directed scenarios plus random traffic, all
// checked against a flat word-array memory model with per-bank rotating priority.
module tb_tcdm_bank_responder;
    localparam int N_PORTS     = 6;
    localparam int N_BANKS     = 8;
    localparam int BANK_WORDS  = 256;
    localparam int TOTAL_WORDS = N_BANKS * BANK_WORDS;

    logic        clk = 1'b0;
    logic        rstN;
    logic        clearIn;
    logic [31:0] conflictCnt;

    logic        reqDrv   [N_PORTS];
    logic        wenDrv   [N_PORTS];
    logic [31:0] addDrv   [N_PORTS];
    logic [31:0] dataDrv  [N_PORTS];
    logic [3:0]  beDrv    [N_PORTS];
    logic        gntObs   [N_PORTS];
    logic        rvalidObs[N_PORTS];
    logic [31:0] rdataObs [N_PORTS];

    hwpe_stream_intf_tcdm tcdmIf [N_PORTS] ();

    for (genvar g = 0; g < N_PORTS; g++) begin : g_conn
        assign tcdmIf[g].req  = reqDrv[g];
        assign tcdmIf[g].wen  = wenDrv[g];
        assign tcdmIf[g].add  = addDrv[g];
        assign tcdmIf[g].be   = beDrv[g];
        assign tcdmIf[g].data = dataDrv[g];
        assign gntObs[g]      = tcdmIf[g].gnt;
        assign rvalidObs[g]   = tcdmIf[g].r_valid;
        assign rdataObs[g]    = tcdmIf[g].r_data;
    end

    tcdm_bank_responder #(
        .N_PORTS   (N_PORTS),
        .N_BANKS   (N_BANKS),
        .BANK_WORDS(BANK_WORDS)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rstN),
        .clear_i       (clearIn),
        .tcdm          (tcdmIf),
        .conflict_cnt_o(conflictCnt)
    );

    always #5 clk = ~clk;

    // Reference state: flat memory indexed by word address, bank = word mod N_BANKS.
    logic [31:0]     refMem       [TOTAL_WORDS];
    bit              refKnown     [TOTAL_WORDS];
    int              refPtr       [N_BANKS];
    bit              refValid     [N_PORTS];
    logic [31:0]     refRdata     [N_PORTS];
    bit              refRdataKnown[N_PORTS];
    bit              expGnt       [N_PORTS];
    longint unsigned refCnt;

    int numAsserts = 0;
    int numFails   = 0;

    function automatic int wordOf(input logic [31:0] a);
        return int'((a >> 2) % TOTAL_WORDS);
    endfunction

    function automatic int bankOf(input logic [31:0] a);
        return wordOf(a) % N_BANKS;
    endfunction

    task automatic checkOutput(input string tag, input int idx, input logic [31:0] observed, input logic [31:0] expected);
        numAsserts++;
        assert (observed === expected) else begin
            numFails++;
            $error("[TB] FAIL %s[%0d]: observed %h expected %h", tag, idx, observed, expected);
        end
    endtask

    task automatic modelReset();
        for (int b = 0; b < N_BANKS; b++) refPtr[b] = 0;
        for (int p = 0; p < N_PORTS; p++) begin
            refValid[p]      = 1'b0;
            refRdata[p]      = '0;
            refRdataKnown[p] = 1'b1;
            expGnt[p]        = 1'b0;
        end
        for (int w = 0; w < TOTAL_WORDS; w++) refKnown[w] = 1'b0;
        refCnt = 0;
    endtask

    task automatic idleAll();
        clearIn = 1'b0;
        for (int p = 0; p < N_PORTS; p++) begin
            reqDrv[p]  = 1'b0;
            wenDrv[p]  = 1'b1;
            addDrv[p]  = '0;
            beDrv[p]   = '0;
            dataDrv[p] = '0;
        end
    endtask

    task automatic setReq(input int p, input logic [31:0] a, input logic wen, input logic [3:0] be, input logic [31:0] d);
        reqDrv[p]  = 1'b1;
        addDrv[p]  = a;
        wenDrv[p]  = wen;
        beDrv[p]   = be;
        dataDrv[p] = d;
    endtask

    task automatic retireGranted();
        for (int p = 0; p < N_PORTS; p++) if (expGnt[p]) reqDrv[p] = 1'b0;
    endtask

    // One clock with the currently driven inputs: grants checked mid-cycle,
    // responses and counter checked just after the rising edge.
    task automatic applyStimulus();
        int conflicts;
        int w;
        @(negedge clk);
        for (int p = 0; p < N_PORTS; p++) expGnt[p] = 1'b0;
        for (int b = 0; b < N_BANKS; b++) begin
            for (int k = 0; k < N_PORTS; k++) begin
                int p;
                p = (refPtr[b] + k) % N_PORTS;
                if (reqDrv[p] && bankOf(addDrv[p]) == b) begin
                    expGnt[p] = 1'b1;
                    break;
                end
            end
        end
        conflicts = 0;
        for (int p = 0; p < N_PORTS; p++) begin
            checkOutput("gnt", p, 32'(gntObs[p]), 32'(expGnt[p]));
            if (reqDrv[p] && !expGnt[p]) conflicts++;
        end
        for (int p = 0; p < N_PORTS; p++) begin
            if (expGnt[p] && wenDrv[p]) begin
                w = wordOf(addDrv[p]);
                refRdata[p]      = refMem[w];
                refRdataKnown[p] = refKnown[w];
            end
        end
        for (int p = 0; p < N_PORTS; p++) begin
            if (expGnt[p] && !wenDrv[p]) begin
                w = wordOf(addDrv[p]);
                for (int i = 0; i < 4; i++) if (beDrv[p][i]) refMem[w][8*i +: 8] = dataDrv[p][8*i +: 8];
                if (beDrv[p] == 4'hF) refKnown[w] = 1'b1;
            end
            if (expGnt[p]) refPtr[bankOf(addDrv[p])] = (p + 1) % N_PORTS;
        end
        if (clearIn) begin
            for (int b = 0; b < N_BANKS; b++) refPtr[b] = 0;
            for (int p = 0; p < N_PORTS; p++) begin
                refValid[p]      = 1'b0;
                refRdata[p]      = '0;
                refRdataKnown[p] = 1'b1;
            end
            refCnt = 0;
        end else begin
            for (int p = 0; p < N_PORTS; p++) refValid[p] = expGnt[p];
            refCnt = refCnt + longint'(conflicts);
            if (refCnt > 64'hFFFF_FFFF) refCnt = 64'hFFFF_FFFF;
        end
        @(posedge clk);
        #1;
        for (int p = 0; p < N_PORTS; p++) begin
            checkOutput("rValid", p, 32'(rvalidObs[p]), 32'(refValid[p]));
            if (refRdataKnown[p]) checkOutput("rData", p, rdataObs[p], refRdata[p]);
        end
        checkOutput("conflictCnt", 0, conflictCnt, refCnt[31:0]);
    endtask

    task automatic oneAccess(input int p, input logic [31:0] a, input logic wen, input logic [3:0] be, input logic [31:0] d);
        idleAll();
        setReq(p, a, wen, be, d);
        applyStimulus();
        retireGranted();
    endtask

    initial begin
        idleAll();
        modelReset();
        rstN = 1'b0;
        repeat (2) @(negedge clk);
        for (int p = 0; p < N_PORTS; p++) begin
            checkOutput("resetRValid", p, 32'(rvalidObs[p]), 32'd0);
            checkOutput("resetRData", p, rdataObs[p], 32'd0);
            checkOutput("resetGnt", p, 32'(gntObs[p]), 32'd0);
        end
        checkOutput("resetCnt", 0, conflictCnt, 32'd0);
        rstN = 1'b1;

        $display("[TB] initialising words 0..63");
        for (int w = 0; w < 64; w++) oneAccess(w % N_PORTS, 32'(w) << 2, 1'b0, 4'hF, $urandom);

        $display("[TB] single port and byte enables");
        oneAccess(0, 32'h0000_0010, 1'b0, 4'hF, 32'hDEAD_BEEF);
        oneAccess(0, 32'h0000_0010, 1'b1, 4'h0, 32'h0);
        checkOutput("readDeadBeef", 0, rdataObs[0], 32'hDEAD_BEEF);
        oneAccess(0, 32'h0000_0010, 1'b0, 4'b0101, 32'h1122_3344);
        oneAccess(0, 32'h0000_0010, 1'b1, 4'h0, 32'h0);
        checkOutput("byteEnable", 0, rdataObs[0], 32'hDE22_BE44);
        oneAccess(0, 32'h0000_0010, 1'b0, 4'b0000, 32'hFFFF_FFFF);
        checkOutput("beZeroValid", 0, 32'(rvalidObs[0]), 32'd1);
        oneAccess(0, 32'h0000_0010, 1'b1, 4'h0, 32'h0);
        checkOutput("beZeroKeeps", 0, rdataObs[0], 32'hDE22_BE44);

        $display("[TB] bank 0 round robin");
        idleAll();
        clearIn = 1'b1;
        applyStimulus();
        clearIn = 1'b0;
        setReq(0, 32'h00, 1'b1, 4'h0, 32'h0);
        setReq(1, 32'h20, 1'b1, 4'h0, 32'h0);
        setReq(2, 32'h40, 1'b1, 4'h0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus();
            checkOutput("rrOrder", k, 32'(rvalidObs[k]), 32'd1);
            retireGranted();
        end
        checkOutput("conflictThree", 0, conflictCnt, 32'd3);

        $display("[TB] parallel banks");
        idleAll();
        for (int p = 0; p < N_PORTS; p++) setReq(p, 32'(p) << 2, 1'b1, 4'h0, 32'h0);
        applyStimulus();
        retireGranted();
        for (int p = 0; p < N_PORTS; p++) checkOutput("parallelValid", p, 32'(rvalidObs[p]), 32'd1);
        checkOutput("parallelNoConflict", 0, conflictCnt, 32'd3);

        $display("[TB] aliasing");
        oneAccess(2, 32'h0000_0000, 1'b0, 4'hF, 32'hCAFE_F00D);
        oneAccess(2, 32'h0000_2000, 1'b1, 4'h0, 32'h0);
        checkOutput("aliasRead", 2, rdataObs[2], 32'hCAFE_F00D);

        $display("[TB] clear in grant cycle");
        idleAll();
        setReq(0, 32'h0000_0010, 1'b1, 4'h0, 32'h0);
        clearIn = 1'b1;
        applyStimulus();
        retireGranted();
        clearIn = 1'b0;
        checkOutput("clearNoValid", 0, 32'(rvalidObs[0]), 32'd0);
        checkOutput("clearCnt", 0, conflictCnt, 32'd0);
        setReq(2, 32'h40, 1'b1, 4'h0, 32'h0);
        setReq(1, 32'h20, 1'b1, 4'h0, 32'h0);
        setReq(0, 32'h00, 1'b1, 4'h0, 32'h0);
        applyStimulus();
        checkOutput("clearPort0First", 0, 32'(rvalidObs[0]), 32'd1);
        retireGranted();
        repeat (2) begin
            applyStimulus();
            retireGranted();
        end

        $display("[TB] random traffic");
        idleAll();
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < N_PORTS; p++) begin
                if (!reqDrv[p] && $urandom_range(0, 99) < 60) begin
                    setReq(p, (32'($urandom) & 32'hFFFF_E000) | (32'($urandom_range(0, 63)) << 2) | (32'($urandom) & 32'h3),
                           1'($urandom_range(0, 1)), 4'($urandom), 32'($urandom));
                end
            end
            clearIn = ($urandom_range(0, 99) < 3);
            applyStimulus();
            retireGranted();
        end

        $display("[TB] reset with a response pending");
        idleAll();
        setReq(0, 32'h0000_0010, 1'b1, 4'h0, 32'h0);
        applyStimulus();
        checkOutput("preResetValid", 0, 32'(rvalidObs[0]), 32'd1);
        #2;
        reqDrv[0] = 1'b0;
        rstN      = 1'b0;
        #1;
        for (int p = 0; p < N_PORTS; p++) checkOutput("asyncResetValid", p, 32'(rvalidObs[p]), 32'd0);
        checkOutput("asyncResetCnt", 0, conflictCnt, 32'd0);
        modelReset();
        @(negedge clk);
        rstN = 1'b1;
        repeat (3) applyStimulus();
        oneAccess(3, 32'h0000_0014, 1'b0, 4'hF, 32'h5A5A_0F0F);
        oneAccess(3, 32'h0000_0014, 1'b1, 4'h0, 32'h0);
        checkOutput("postResetRead", 3, rdataObs[3], 32'h5A5A_0F0F);

        $display("End of test - %0d assertions evaluated, %0d failures", numAsserts, numFails);
        $finish;
    end

endmodule
